mem_stage: RTL

Memory-access stage of the five-stage MIPS/DLX pipeline, sitting directly downstream of the EX/MEM latch and upstream of writeback. It consumes the EX/MEM control, ALU result, store data and destination register, performs word loads/stores on an internal data RAM with a configurable number of wait states, and registers the MEM/WB results. While a multi-cycle access is in flight it raises `stall` so the hazard logic freezes the upstream latches.

---
 rtl/mem_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: word load/store on an internal RAM with
// WAIT_STATES extra cycles per access. Optional stall-cycle counter: MEM_STAGE_PERF_EN.
module mem_stage #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  M_control_in,
    input  logic [1:0]  WB_control_in,
    input  logic [31:0] ALU_out_in,
    input  logic [31:0] data_write_in,
    input  logic [4:0]  rw_in,
    output logic [1:0]  WB_control_out,
    output logic [31:0] read_data_out,
    output logic [31:0] ALU_out_out,
    output logic [4:0]  rw_out,
    output logic        stall,
    output logic        mem_fault,
    output logic [31:0] perf_stall_cycles
);

    localparam int unsigned DEPTH    = 1 << ADDR_BITS;
    localparam int unsigned CNT_W    = 3;
    localparam bit          HAS_WAIT = (WAIT_STATES != 0);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [31:0]          ram [DEPTH];
    logic [ADDR_BITS-1:0] idx;
    logic                 req;
    logic                 illegal;
    logic                 is_load;
    logic                 is_store;
    logic                 commit;
    logic                 ram_we;

    // Request decode; inputs are held by upstream while stalled, so they stay valid in WAIT.
    always_comb begin
        idx      = ALU_out_in[ADDR_BITS+1:2];
        req      = enable && (M_control_in != 2'b00);
        illegal  = (M_control_in != 2'b00) &&
                   ((M_control_in == 2'b11) || (ALU_out_in[1:0] != 2'b00));
        is_load  = (M_control_in == 2'b10) && !illegal;
        is_store = (M_control_in == 2'b01) && !illegal;
        commit   = enable && (((state == S_IDLE) && !(req && HAS_WAIT)) ||
                              ((state == S_WAIT) && (cnt == '0)));
        ram_we   = reset && commit && is_store;
        stall    = reset && (((state == S_IDLE) && req && HAS_WAIT) ||
                             ((state == S_WAIT) && (cnt != '0)));
    end

    // Access FSM and MEM/WB latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            WB_control_out <= '0;
            read_data_out  <= '0;
            ALU_out_out    <= '0;
            rw_out         <= '0;
            mem_fault      <= 1'b0;
        end else if (enable) begin
            case (state)
                S_IDLE: begin
                    if (req && HAS_WAIT) begin
                        state <= S_WAIT;
                        cnt   <= CNT_W'(WAIT_STATES - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            mem_fault <= commit && illegal;
            if (commit) begin
                ALU_out_out    <= ALU_out_in;
                rw_out         <= rw_in;
                WB_control_out <= illegal ? 2'b00 : WB_control_in;
                read_data_out  <= is_load ? ram[idx] : 32'h0;
            end
        end
    end

    // Data RAM is not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx] <= data_write_in;
        end
    end

`ifdef MEM_STAGE_PERF_EN
    // Saturating count of enabled stall cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
        end else if (enable && stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    assign perf_stall_cycles = '0;
`endif

endmodule
